// File: rtl/mma_uart_loader.sv
// UART command decoder and A/B matrix loader for the MMA core.
// Optional inter-byte timeout is enabled with `define MMA_LOADER_TIMEOUT_EN.
module mma_uart_loader #(
  parameter int MAX_DIM        = 8,
  parameter int ADDR_W         = 6,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_ready,
  input  logic              rx_error,
  input  logic              tx_busy,
  output logic [7:0]        tx_data,
  output logic              tx_begin,
  output logic              wr_en,
  output logic              wr_sel,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [31:0]       a_rows,
  output logic [31:0]       a_cols,
  output logic [31:0]       b_rows,
  output logic [31:0]       b_cols,
  output logic              a_valid,
  output logic              b_valid,
  output logic              cmd_valid,
  output logic [7:0]        cmd_code,
  output logic              busy
);
  localparam int DIM_W = $clog2(MAX_DIM + 1);

  typedef enum logic [2:0] {IDLE, HDR, DATA, SEND_ACK, SEND_ERR} state_t;
  state_t state, state_next;

  logic [2:0]           hdr_cnt;
  logic [1:0]           byte_cnt;
  logic [55:0]          hdr_sr;
  logic [23:0]          word_sr;
  logic [ADDR_W-1:0]    addr, last_addr;
  logic [31:0]          rows_new, cols_new;
  logic [2*DIM_W-1:0]   elem_cnt;
  logic                 dims_ok, hdr_done, word_done, last_word, timeout_hit;

  // Header fields as they stand once the 8th byte is on rx_data.
  always_comb begin
    rows_new  = hdr_sr[55:24];
    cols_new  = {hdr_sr[23:0], rx_data};
    dims_ok   = (rows_new != '0) && (rows_new <= 32'(MAX_DIM)) &&
                (cols_new != '0) && (cols_new <= 32'(MAX_DIM));
    elem_cnt  = (2*DIM_W)'(rows_new[DIM_W-1:0]) * (2*DIM_W)'(cols_new[DIM_W-1:0]);
    hdr_done  = (state == HDR)  && rx_ready && !rx_error && (hdr_cnt == 3'd7);
    word_done = (state == DATA) && rx_ready && !rx_error && (byte_cnt == 2'd3);
    last_word = word_done && (addr == last_addr);
  end

`ifdef MMA_LOADER_TIMEOUT_EN
  logic [31:0] gap_cnt;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      gap_cnt <= '0;
    else if ((state == HDR || state == DATA) && !rx_ready)
      gap_cnt <= gap_cnt + 32'd1;
    else
      gap_cnt <= '0;
  end
  assign timeout_hit = (state == HDR || state == DATA) && !rx_ready &&
                       (gap_cnt >= 32'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:     if (rx_ready && (rx_data == 8'h01 || rx_data == 8'h02)) state_next = HDR;
      HDR:      if (rx_error || timeout_hit) state_next = SEND_ERR;
                else if (hdr_done) state_next = dims_ok ? DATA : SEND_ERR;
      DATA:     if (rx_error || timeout_hit) state_next = SEND_ERR;
                else if (last_word) state_next = SEND_ACK;
      SEND_ACK,
      SEND_ERR: if (!tx_busy) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_data   <= '0;
      tx_begin  <= 1'b0;
      wr_en     <= 1'b0;
      wr_sel    <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      a_rows    <= '0;
      a_cols    <= '0;
      b_rows    <= '0;
      b_cols    <= '0;
      a_valid   <= 1'b0;
      b_valid   <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_code  <= '0;
      hdr_cnt   <= '0;
      byte_cnt  <= '0;
      hdr_sr    <= '0;
      word_sr   <= '0;
      addr      <= '0;
      last_addr <= '0;
    end else begin
      tx_begin  <= 1'b0;
      wr_en     <= 1'b0;
      cmd_valid <= 1'b0;
      case (state)
        IDLE: if (rx_ready) begin
          hdr_cnt  <= '0;
          byte_cnt <= '0;
          if (rx_data == 8'h01) begin
            wr_sel  <= 1'b0;
            a_valid <= 1'b0;
          end else if (rx_data == 8'h02) begin
            wr_sel  <= 1'b1;
            b_valid <= 1'b0;
          end else begin
            cmd_code  <= rx_data;
            cmd_valid <= 1'b1;
          end
        end
        HDR: if (rx_ready && !rx_error) begin
          hdr_sr  <= {hdr_sr[47:0], rx_data};
          hdr_cnt <= hdr_cnt + 3'd1;
          if (hdr_done && dims_ok) begin
            if (wr_sel) begin
              b_rows <= rows_new;
              b_cols <= cols_new;
            end else begin
              a_rows <= rows_new;
              a_cols <= cols_new;
            end
            last_addr <= ADDR_W'(elem_cnt - (2*DIM_W)'(1));
            addr      <= '0;
            byte_cnt  <= '0;
          end
        end
        DATA: if (rx_ready && !rx_error) begin
          word_sr  <= {word_sr[15:0], rx_data};
          byte_cnt <= byte_cnt + 2'd1;
          if (word_done) begin
            wr_en   <= 1'b1;
            wr_addr <= addr;
            wr_data <= {word_sr, rx_data};
            addr    <= addr + ADDR_W'(1);
            if (last_word) begin
              if (wr_sel) b_valid <= 1'b1;
              else        a_valid <= 1'b1;
            end
          end
        end
        SEND_ACK, SEND_ERR: if (!tx_busy) begin
          tx_begin <= 1'b1;
          tx_data  <= (state == SEND_ACK) ? 8'h06 : 8'hAA;
        end
        default: ;
      endcase
    end
  end
endmodule
